// File: rtl/cnt_cmp_unit.sv
// cnt_cmp_unit: compare/wrap/PWM unit tracking an upstream 4-bit counter,
// with a double-buffered compare value and a saturating match counter.
module cnt_cmp_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] cnt,
    input  logic       en,
    input  logic       clr,
    input  logic       cfg_valid,
    input  logic [3:0] cfg_cmp,
    output logic       cfg_ready,
    output logic       match,
    output logic       wrap,
    output logic       pwm,
    output logic [7:0] evt_cnt,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;
    state_t     state;
    logic [3:0] cnt_q, cmp_act, cmp_shadow;
    logic       pending, wrap_hit, live;
    assign wrap_hit  = cnt_q == 4'hF && cnt == 4'h0;
    assign live      = state == RUN && en;
    assign cfg_ready = !pending;
    assign busy      = state != IDLE;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt_q      <= '0;
            cmp_act    <= '0;
            cmp_shadow <= '0;
            pending    <= 1'b0;
            match      <= 1'b0;
            wrap       <= 1'b0;
            pwm        <= 1'b0;
            evt_cnt    <= '0;
        end else begin
            cnt_q   <= cnt;
            state   <= !en ? IDLE : state == IDLE ? ARM : (state == ARM && cnt == 4'h0) ? RUN : state;
            match   <= live && cnt == cmp_act && cnt != cnt_q;
            wrap    <= live && wrap_hit;
            pwm     <= live && cnt < cmp_act;
            evt_cnt <= clr ? 8'h00 : (match && evt_cnt != 8'hFF) ? evt_cnt + 8'd1 : evt_cnt;
            // While running, the new compare value only takes effect at a lap boundary
            if (pending && (state != RUN || wrap_hit)) begin
                cmp_act <= cmp_shadow;
                pending <= 1'b0;
            end else if (cfg_valid && !pending) begin
                cmp_shadow <= cfg_cmp;
                pending    <= 1'b1;
            end
        end
    end
endmodule
